// File: rtl/rr_grant_scheduler.sv
// rtl/rr_grant_scheduler.sv - three-requester round-robin grant scheduler with hold limit
module rr_grant_scheduler #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    output logic [2:0] granted_req,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_ptr;
    logic [1:0] r_owner;
    logic [7:0] r_hold_cnt;
    logic       r_preempt;

    logic [1:0] w_cand0;
    logic [1:0] w_cand1;
    logic [1:0] w_cand2;
    logic       w_found;
    logic [1:0] w_winner;
    logic [2:0] w_owner_oh;
    logic       w_owner_req;
    logic       w_others;
    logic       w_timeout;
    logic [1:0] w_owner_next;

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        logic [2:0] oh;
        oh = 3'b000;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Scan order ptr, ptr+1, ptr+2 (mod 3); the first requester found wins.
    always_comb begin
        w_cand0  = r_ptr;
        w_cand1  = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
        w_cand2  = (r_ptr == 2'd0) ? 2'd2 : r_ptr - 2'd1;
        w_found  = 1'b1;
        w_winner = w_cand0;
        if (|(req & onehot3(w_cand0))) begin
            w_winner = w_cand0;
        end else if (|(req & onehot3(w_cand1))) begin
            w_winner = w_cand1;
        end else if (|(req & onehot3(w_cand2))) begin
            w_winner = w_cand2;
        end else begin
            w_found = 1'b0;
        end
    end

    // Owner status: still requesting, competitors waiting, hold limit reached.
    always_comb begin
        w_owner_oh   = onehot3(r_owner);
        w_owner_req  = |(req & w_owner_oh);
        w_others     = |(req & ~w_owner_oh);
        w_timeout    = w_owner_req && (r_hold_cnt == HOLD_LAST) && w_others;
        w_owner_next = (r_owner == 2'd2) ? 2'd0 : r_owner + 2'd1;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; release has priority over timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (|req) w_next_state = ARB;
            ARB:     w_next_state = w_found ? GRANT : IDLE;
            GRANT:   if (!w_owner_req || w_timeout) w_next_state = GAP;
            GAP:     w_next_state = ARB;
            default: w_next_state = IDLE;
        endcase
    end

    // Owner latch, hold counter, pointer advance and preempt flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr      <= 2'd0;
            r_owner    <= 2'd0;
            r_hold_cnt <= 8'd0;
            r_preempt  <= 1'b0;
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                ARB: begin
                    if (w_found) begin
                        r_owner    <= w_winner;
                        r_hold_cnt <= 8'd0;
                    end
                end
                GRANT: begin
                    if (!w_owner_req || w_timeout) begin
                        r_ptr     <= w_owner_next;
                        r_preempt <= w_owner_req;
                    end else if (r_hold_cnt != HOLD_LAST) begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Moore output decode from registered state.
    always_comb begin
        granted_req = 3'b000;
        grant_id    = 2'd3;
        busy        = (r_state != IDLE);
        preempt     = (r_state == GAP) && r_preempt;
        if (r_state == GRANT) begin
            granted_req = w_owner_oh;
            grant_id    = r_owner;
        end
    end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// tb/tb_rr_grant_scheduler.sv - table-driven bench for rr_grant_scheduler
module tb_rr_grant_scheduler;

    logic       clk;
    logic       reset;
    logic [2:0] req;
    logic [2:0] g4;
    logic [1:0] id4;
    logic       busy4;
    logic       pre4;
    logic [2:0] g1;
    logic [1:0] id1;
    logic       busy1;
    logic       pre1;

    int n_cmp;
    int n_bad;
    bit inv_on;

    typedef struct {
        logic [2:0] req;
        logic [2:0] g;
        logic [1:0] id;
        logic       busy;
        logic       pre;
    } vec_t;

    vec_t tbl[$];

    rr_grant_scheduler #(.HOLD_MAX(4)) dut4 (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .granted_req (g4),
        .grant_id    (id4),
        .busy        (busy4),
        .preempt     (pre4)
    );

    rr_grant_scheduler #(.HOLD_MAX(1)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .granted_req (g1),
        .grant_id    (id1),
        .busy        (busy1),
        .preempt     (pre1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [2:0] r, input logic [2:0] g, input logic [1:0] id,
                       input logic b, input logic p);
        vec_t v;
        v.req  = r;
        v.g    = g;
        v.id   = id;
        v.busy = b;
        v.pre  = p;
        tbl.push_back(v);
    endtask

    task automatic step(input logic [2:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string name, input logic [2:0] g, input logic [1:0] id,
                        input logic b, input logic p);
        check({name, ".granted_req"}, int'(g4), int'(g));
        check({name, ".grant_id"}, int'(id4), int'(id));
        check({name, ".busy"}, int'(busy4), int'(b));
        check({name, ".preempt"}, int'(pre4), int'(p));
    endtask

    task automatic chk1(input string name, input logic [2:0] g, input logic [1:0] id,
                        input logic p);
        check({name, ".granted_req"}, int'(g1), int'(g));
        check({name, ".grant_id"}, int'(id1), int'(id));
        check({name, ".preempt"}, int'(pre1), int'(p));
    endtask

    // Structural invariants on both instances, sampled away from the active edge.
    always @(negedge clk) begin
        if (inv_on) begin
            n_cmp++;
            if (!$onehot0(g4) || ((id4 == 2'd3) != (g4 == 3'b000))) begin
                n_bad++;
                $display("FAIL inv4: granted_req=%b grant_id=%0d", g4, id4);
            end
            n_cmp++;
            if (!$onehot0(g1) || ((id1 == 2'd3) != (g1 == 3'b000))) begin
                n_bad++;
                $display("FAIL inv1: granted_req=%b grant_id=%0d", g1, id1);
            end
        end
    end

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        inv_on = 1'b0;
        reset  = 1'b0;
        req    = 3'b000;

        // Round robin, each owner releasing after two grant cycles (ptr starts 0).
        add(3'b111, 3'b000, 2'd3, 1, 0);
        add(3'b111, 3'b001, 2'd0, 1, 0);
        add(3'b111, 3'b001, 2'd0, 1, 0);
        add(3'b110, 3'b000, 2'd3, 1, 0);
        add(3'b111, 3'b000, 2'd3, 1, 0);
        add(3'b111, 3'b010, 2'd1, 1, 0);
        add(3'b111, 3'b010, 2'd1, 1, 0);
        add(3'b101, 3'b000, 2'd3, 1, 0);
        add(3'b111, 3'b000, 2'd3, 1, 0);
        add(3'b111, 3'b100, 2'd2, 1, 0);
        add(3'b111, 3'b100, 2'd2, 1, 0);
        add(3'b011, 3'b000, 2'd3, 1, 0);
        add(3'b111, 3'b000, 2'd3, 1, 0);
        add(3'b111, 3'b001, 2'd0, 1, 0);
        add(3'b110, 3'b000, 2'd3, 1, 0);
        add(3'b000, 3'b000, 2'd3, 1, 0);
        add(3'b000, 3'b000, 2'd3, 0, 0);
        // Single request on requester 1 (ptr now 1).
        add(3'b010, 3'b000, 2'd3, 1, 0);
        add(3'b010, 3'b010, 2'd1, 1, 0);
        add(3'b010, 3'b010, 2'd1, 1, 0);
        add(3'b000, 3'b000, 2'd3, 1, 0);
        add(3'b000, 3'b000, 2'd3, 1, 0);
        add(3'b000, 3'b000, 2'd3, 0, 0);
        // Timeout with HOLD_MAX=4, req=011 held (ptr now 2 -> owner 0 first).
        add(3'b011, 3'b000, 2'd3, 1, 0);
        for (int i = 0; i < 4; i++) add(3'b011, 3'b001, 2'd0, 1, 0);
        add(3'b011, 3'b000, 2'd3, 1, 1);
        add(3'b011, 3'b000, 2'd3, 1, 0);
        for (int i = 0; i < 4; i++) add(3'b011, 3'b010, 2'd1, 1, 0);
        add(3'b011, 3'b000, 2'd3, 1, 1);
        add(3'b011, 3'b000, 2'd3, 1, 0);
        add(3'b011, 3'b001, 2'd0, 1, 0);
        add(3'b000, 3'b000, 2'd3, 1, 0);
        add(3'b000, 3'b000, 2'd3, 1, 0);
        add(3'b000, 3'b000, 2'd3, 0, 0);
        // No competitor: requester 2 held 20 cycles, never preempted.
        add(3'b100, 3'b000, 2'd3, 1, 0);
        for (int i = 0; i < 19; i++) add(3'b100, 3'b100, 2'd2, 1, 0);
        add(3'b000, 3'b000, 2'd3, 1, 0);
        add(3'b000, 3'b000, 2'd3, 1, 0);
        add(3'b000, 3'b000, 2'd3, 0, 0);
        // Request dropped before ARB evaluates it: no grant.
        add(3'b100, 3'b000, 2'd3, 1, 0);
        add(3'b000, 3'b000, 2'd3, 0, 0);
        add(3'b000, 3'b000, 2'd3, 0, 0);

        #1;
        chk4("reset", 3'b000, 2'd3, 0, 0);
        @(negedge clk);
        reset  = 1'b1;
        inv_on = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].req);
            chk4($sformatf("vec%0d", k), tbl[k].g, tbl[k].id, tbl[k].busy, tbl[k].pre);
        end

        // Async reset mid-grant with ptr=2, then ptr=0 scan picks requester 1.
        step(3'b010);
        step(3'b010);
        chk4("ar_g1", 3'b010, 2'd1, 1, 0);
        step(3'b000);
        step(3'b000);
        step(3'b000);
        step(3'b001);
        step(3'b001);
        chk4("ar_g0", 3'b001, 2'd0, 1, 0);
        #3;
        reset = 1'b0;
        #1;
        chk4("ar_async", 3'b000, 2'd3, 0, 0);
        req = 3'b110;
        @(posedge clk);
        #1;
        chk4("ar_held", 3'b000, 2'd3, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk4("ar_arb", 3'b000, 2'd3, 1, 0);
        @(posedge clk);
        #1;
        chk4("ar_first", 3'b010, 2'd1, 1, 0);

        // HOLD_MAX=1: preempted after exactly one grant cycle.
        @(negedge clk);
        reset = 1'b0;
        req   = 3'b011;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk1("h1_arb", 3'b000, 2'd3, 0);
        @(posedge clk);
        #1;
        chk1("h1_g0", 3'b001, 2'd0, 0);
        @(posedge clk);
        #1;
        chk1("h1_gap", 3'b000, 2'd3, 1);
        @(posedge clk);
        #1;
        chk1("h1_arb2", 3'b000, 2'd3, 0);
        @(posedge clk);
        #1;
        chk1("h1_g1", 3'b010, 2'd1, 0);
        @(posedge clk);
        #1;
        chk1("h1_gap2", 3'b000, 2'd3, 1);

        @(negedge clk);
        inv_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
